// File: rtl/fisqr_pkg.sv
// Shared types and defaults for the fast_inv_sqrt request scheduler.
package fisqr_pkg;

    localparam int unsigned FISQR_DATA_W  = 27;
    localparam int unsigned FISQR_LATENCY = 5;
    // Tag index field is sized for the largest legal requester count (16).
    localparam int unsigned FISQR_IDX_W   = 4;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALT
    } fisqr_state_e;

    typedef struct packed {
        logic                   valid;
        logic [FISQR_IDX_W-1:0] idx;
    } fisqr_tag_t;

endpackage

// File: rtl/fisqr_rr_arb.sv
// Combinational round-robin grant: search starts one past last_grant_i and wraps.
module fisqr_rr_arb #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_o
);

    always_comb begin
        int unsigned cand;
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        cand        = 0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = (32'(last_grant_i) + off) % N_REQ;
            if (!any_o && req_valid_i[cand]) begin
                grant_o[cand] = 1'b1;
                grant_idx_o   = IDX_W'(cand);
                any_o         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fisqr_sched.sv
// Round-robin sharing of one fast_inv_sqrt pipeline among N_REQ requesters,
// with tag-routed returns and drain control. Optional counters: FISQR_SCHED_PERF_EN.
module fisqr_sched
    import fisqr_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = FISQR_DATA_W,
    parameter int unsigned LATENCY = FISQR_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*DATA_W-1:0]      req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic [DATA_W-1:0]            fisqr_in,
    input  logic [DATA_W-1:0]            fisqr_out,
    output logic [N_REQ-1:0]             resp_valid,
    output logic [DATA_W-1:0]            resp_data,
    input  logic                         drain_req,
    output logic                         drained,
    output logic [$clog2(LATENCY+3)-1:0] in_flight
`ifdef FISQR_SCHED_PERF_EN
    ,
    output logic [31:0]                  perf_issued,
    output logic [31:0]                  perf_conflict
`endif
);

    localparam int unsigned IDX_W = (N_REQ < 2) ? 1 : $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(LATENCY + 3);
    // Stage 0 sits beside fisqr_in; the pipeline's input register adds one
    // stage ahead of its LATENCY, so the last stage lines up with fisqr_out.
    localparam int unsigned TAG_N = LATENCY + 2;

    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
        $error("fisqr_sched: N_REQ must be in 2..16");
    end

    fisqr_state_e            state_q, state_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [DATA_W-1:0]       fisqr_in_q, fisqr_in_d;
    fisqr_tag_t              tag_q [TAG_N];
    fisqr_tag_t              tag_d;
    fisqr_tag_t              ret_tag;
    logic [N_REQ-1:0]        resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]       resp_data_q, resp_data_d;
    logic [CNT_W-1:0]        in_flight_q, in_flight_d;

    logic [N_REQ-1:0]        arb_grant;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_any;
    logic                    run_ok;
    logic                    xfer;
    logic                    ret;

    fisqr_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx),
        .any_o        (arb_any)
    );

    assign run_ok    = (state_q == RUN) && !rst;
    assign req_ready = run_ok ? arb_grant : '0;
    assign xfer      = run_ok && arb_any;
    assign ret_tag   = tag_q[TAG_N-1];
    assign ret       = ret_tag.valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (drain_req) state_d = DRAIN;
            DRAIN:   if (in_flight_q == '0) state_d = HALT;
            HALT:    if (!drain_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        tag_d        = '0;
        fisqr_in_d   = fisqr_in_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            tag_d.valid  = 1'b1;
            tag_d.idx    = FISQR_IDX_W'(arb_idx);
            fisqr_in_d   = req_data[arb_idx*DATA_W +: DATA_W];
            last_grant_d = arb_idx;
        end

        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        if (ret) begin
            resp_valid_d[ret_tag.idx] = 1'b1;
            resp_data_d               = fisqr_out;
        end

        in_flight_d = in_flight_q;
        if (xfer && !ret) begin
            in_flight_d = in_flight_q + CNT_W'(1);
        end else if (!xfer && ret) begin
            in_flight_d = in_flight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            last_grant_q <= IDX_W'(N_REQ - 1);
            fisqr_in_q   <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            in_flight_q  <= '0;
            for (int unsigned i = 0; i < TAG_N; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            fisqr_in_q   <= fisqr_in_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            in_flight_q  <= in_flight_d;
            tag_q[0]     <= tag_d;
            for (int unsigned i = 1; i < TAG_N; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign fisqr_in   = fisqr_in_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign in_flight  = in_flight_q;
    assign drained    = (state_q == HALT);

`ifdef FISQR_SCHED_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_conflict_q, perf_conflict_d;

    always_comb begin
        perf_issued_d   = perf_issued_q + (xfer ? 32'd1 : 32'd0);
        perf_conflict_d = perf_conflict_q;
        if (state_q == RUN && $countones(req_valid) >= 2) begin
            perf_conflict_d = perf_conflict_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_q   <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_issued_q   <= perf_issued_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_issued   = perf_issued_q;
    assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_fisqr_sched.sv
// Bench for fisqr_sched: behavioural pipeline stand-in plus a transaction-level
// reference model checked every cycle, with directed and random phases.
module tb_fisqr_sched;

    localparam int N = 4;
    localparam int W = 27;
    localparam int L = 5;
    localparam int CW = $clog2(L + 3);

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*W-1:0]    req_data;
    logic [N-1:0]      req_ready;
    logic [W-1:0]      fisqr_in;
    logic [W-1:0]      fisqr_out;
    logic [N-1:0]      resp_valid;
    logic [W-1:0]      resp_data;
    logic              drain_req;
    logic              drained;
    logic [CW-1:0]     in_flight;
`ifdef FISQR_SCHED_PERF_EN
    logic [31:0]       perf_issued;
    logic [31:0]       perf_conflict;
`endif

    fisqr_sched #(
        .N_REQ   (N),
        .DATA_W  (W),
        .LATENCY (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fisqr_in   (fisqr_in),
        .fisqr_out  (fisqr_out),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .drain_req  (drain_req),
        .drained    (drained),
        .in_flight  (in_flight)
`ifdef FISQR_SCHED_PERF_EN
        ,
        .perf_issued   (perf_issued),
        .perf_conflict (perf_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for fast_inv_sqrt: input register then LATENCY stages.
    function automatic logic [W-1:0] fsq(input logic [W-1:0] x);
        logic [W-1:0] magic;
        magic = 27'h5F3759D;
        return magic - (x >> 1);
    endfunction

    logic [W-1:0] pipe [0:L];
    always @(posedge clk) begin
        pipe[0] <= fisqr_in;
        for (int i = 1; i <= L; i++) pipe[i] <= pipe[i-1];
    end
    assign fisqr_out = fsq(pipe[L]);

    // Reference model: pending results keyed by the edge they must appear after.
    typedef struct {
        int           due;
        int           idx;
        logic [W-1:0] data;
    } exp_t;

    localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

    exp_t         pend[$];
    int           m_last, m_mode, m_inflight, cyc;
    logic [N-1:0] m_rv;
    logic [W-1:0] m_rd, m_fin;
    logic [N-1:0] glog[$];
    logic [N-1:0] rlog[$];
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_last = N - 1; m_mode = M_RUN; m_inflight = 0;
        m_rv = '0; m_rd = '0; m_fin = '0;
    endtask

    task automatic step();
        logic [N-1:0] eg;
        int           gi, retn, c;
        @(negedge clk);
        eg = '0; gi = -1;
        if (!rst && m_mode == M_RUN) begin
            for (int o = 1; o <= N; o++) begin
                c = (m_last + o) % N;
                if (gi < 0 && req_valid[c]) gi = c;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        chk("req_ready",  64'(req_ready),  64'(eg));
        chk("resp_valid", 64'(resp_valid), 64'(m_rv));
        chk("resp_data",  64'(resp_data),  64'(m_rd));
        chk("fisqr_in",   64'(fisqr_in),   64'(m_fin));
        chk("in_flight",  64'(in_flight),  64'(m_inflight));
        chk("drained",    64'(drained),    64'(m_mode == M_HALT));
        glog.push_back(req_ready);
        rlog.push_back(resp_valid);
        if (rst) begin
            model_reset();
        end else begin
            retn = 0;
            m_rv = '0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                m_rv[pend[0].idx] = 1'b1;
                m_rd = pend[0].data;
                void'(pend.pop_front());
                retn = 1;
            end
            case (m_mode)
                M_RUN:   if (drain_req) m_mode = M_DRAIN;
                M_DRAIN: if (m_inflight == 0) m_mode = M_HALT;
                default: if (!drain_req) m_mode = M_RUN;
            endcase
            if (gi >= 0) begin
                pend.push_back('{cyc + L + 2, gi, fsq(req_data[gi*W +: W])});
                m_fin  = req_data[gi*W +: W];
                m_last = gi;
            end
            m_inflight = m_inflight + (gi >= 0 ? 1 : 0) - retn;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; drain_req = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
    endtask

    int base, cnt;
    logic [N-1:0] exp_g;
    logic [W-1:0] d;

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; drain_req = 1'b0; cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // Reset state
        chk("rst_in_flight", 64'(in_flight), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);

        // Single request: 7-cycle turnaround, literal result
        req_valid = 4'b0001; req_data[0 +: W] = 27'h0800000;
        step();
        chk("single_grant", 64'(glog[glog.size()-1]), 64'(4'b0001));
        chk("single_inflight1", 64'(in_flight), 64'd1);
        req_valid = '0;
        repeat (6) step();
        chk("single_early", 64'(resp_valid), 64'd0);
        step();
        chk("single_resp_valid", 64'(resp_valid), 64'(4'b0001));
        chk("single_resp_data", 64'(resp_data), 64'(27'h5B3759D));
        chk("single_inflight0", 64'(in_flight), 64'd0);

        // Contention: all valid for 8 cycles
        do_reset();
        base = glog.size();
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin rand_data(); step(); end
        req_valid = '0;
        repeat (9) step();
        for (int i = 0; i < 8; i++) begin
            exp_g = 4'b0001 << (i % 4);
            chk("contend_grant", 64'(glog[base+i]), 64'(exp_g));
            chk("contend_resp", 64'(rlog[base+i+8]), 64'(exp_g));
        end

        // Fairness skip: only 1 and 3 valid
        do_reset();
        base = glog.size();
        req_valid = 4'b1010;
        for (int i = 0; i < 8; i++) begin rand_data(); step(); end
        req_valid = '0;
        for (int i = 0; i < 8; i++) begin
            exp_g = (i % 2 == 0) ? 4'b0010 : 4'b1000;
            chk("skip_grant", 64'(glog[base+i]), 64'(exp_g));
        end
        repeat (9) step();

        // Drain: three transfers from requester 2, then halt and resume
        do_reset();
        base = glog.size();
        rand_data();
        req_valid = 4'b0100;
        step(); step();
        drain_req = 1'b1;
        step();
        chk("drain_inflight3", 64'(in_flight), 64'd3);
        repeat (7) step();
        chk("drain_inflight0", 64'(in_flight), 64'd0);
        chk("drain_not_yet", 64'(drained), 64'd0);
        step();
        chk("drain_drained", 64'(drained), 64'd1);
        repeat (2) step();
        cnt = 0;
        for (int i = base; i < glog.size(); i++) if (glog[i] != '0) cnt++;
        chk("drain_grant_count", 64'(cnt), 64'd3);
        cnt = 0;
        for (int i = base; i < rlog.size(); i++) if (rlog[i] != '0) cnt++;
        chk("drain_resp_count", 64'(cnt), 64'd3);
        drain_req = 1'b0;
        step();
        chk("drain_halt_nogrant", 64'(glog[glog.size()-1]), 64'd0);
        step();
        chk("drain_resume", 64'(glog[glog.size()-1]), 64'(4'b0100));
        req_valid = '0;
        repeat (9) step();

        // Reset with four operands in flight
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin rand_data(); step(); end
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_fisqr_in", 64'(fisqr_in), 64'd0);
        chk("mid_rst_resp_data", 64'(resp_data), 64'd0);
        chk("mid_rst_inflight", 64'(in_flight), 64'd0);
        chk("mid_rst_drained", 64'(drained), 64'd0);
        base = rlog.size();
        repeat (10) step();
        cnt = 0;
        for (int i = base; i < rlog.size(); i++) if (rlog[i] != '0) cnt++;
        chk("mid_rst_no_resp", 64'(cnt), 64'd0);
        d = W'($urandom);
        req_data[1*W +: W] = d;
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        repeat (7) step();
        chk("post_rst_resp_valid", 64'(resp_valid), 64'(4'b0010));
        chk("post_rst_resp_data", 64'(resp_data), 64'(fsq(d)));

`ifdef FISQR_SCHED_PERF_EN
        // Counters over 10 contended cycles
        do_reset();
        req_valid = 4'b0011;
        repeat (10) begin rand_data(); step(); end
        req_valid = '0;
        chk("perf_conflict", 64'(perf_conflict), 64'd10);
        chk("perf_issued", 64'(perf_issued), 64'd10);
        repeat (9) step();
`endif

        // Random traffic with drain toggling and occasional reset
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req_valid = N'($urandom);
            rand_data();
            if ($urandom_range(0, 24) == 0) drain_req = ~drain_req;
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0; drain_req = 1'b0; req_valid = '0;
        repeat (12) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
